// File: rtl/tm1638_frame_driver_if.sv
// TM1638 three-wire pad bundle: serial clock, strobe and a split bidirectional data line.
interface tm1638_frame_driver_if;
    logic tm1638_clk;
    logic tm1638_stb;
    logic tm1638_dio_in;
    logic tm1638_dio_out;
    logic tm1638_dio_out_en;

    modport master (
        output tm1638_clk,
        output tm1638_stb,
        output tm1638_dio_out,
        output tm1638_dio_out_en,
        input  tm1638_dio_in
    );

    modport slave (
        input  tm1638_clk,
        input  tm1638_stb,
        input  tm1638_dio_out,
        input  tm1638_dio_out_en,
        output tm1638_dio_in
    );
endinterface

// File: rtl/tm1638_frame_driver.sv
// Continuous TM1638 refresh: each frame writes a snapshot of digits/LEDs/brightness
// and reads the 32 raw key bits back.
module tm1638_frame_driver #(
    parameter int CLK_DIV  = 16,
    parameter int N_DIGITS = 8,
    parameter int N_LEDS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [8*N_DIGITS-1:0] digits,
    input  logic [N_LEDS-1:0]     leds,
    input  logic [2:0]            brightness,
    input  logic                  display_on,
    output logic [31:0]           keys,
    output logic                  keys_valid,
    output logic                  frame_done,
    tm1638_frame_driver_if.master bus
);

    localparam int DW = $clog2(2 * CLK_DIV) + 1;
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, STB_SETUP, BIT_LO, BIT_HI, TURN, STB_GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_reg, div_next;
    logic [2:0]      bit_reg, bit_next;
    logic [4:0]      byte_reg, byte_next;
    logic [1:0]      txn_reg, txn_next;
    logic [31:0]     key_shift_reg, key_shift_next;
    logic [31:0]     keys_reg, keys_next;
    logic            keys_valid_reg, keys_valid_next;
    logic            frame_done_reg, frame_done_next;
    logic            tclk_reg, tclk_next;
    logic            stb_reg, stb_next;
    logic            dio_out_reg, dio_out_next;
    logic            dio_en_reg, dio_en_next;
    logic            snap;

    logic [63:0]     digits_ext;
    logic [7:0]      leds_ext;
    logic [63:0]     digit_snap_reg;
    logic [7:0]      led_snap_reg;
    logic [2:0]      bright_snap_reg;
    logic            on_snap_reg;
    logic [127:0]    data_bytes;

    logic [4:0]      last_byte;
    logic            reading;
    logic [1:0]      key_byte;
    logic [4:0]      key_idx;
    logic [3:0]      data_idx;
    logic [7:0]      tx_byte;

    // Unused digit/LED lanes are tied to zero so the 16 data bytes are always sent.
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        if (gi < N_DIGITS) begin : g_dig
            assign digits_ext[8*gi +: 8] = digits[8*gi +: 8];
        end else begin : g_nodig
            assign digits_ext[8*gi +: 8] = 8'h00;
        end
        if (gi < N_LEDS) begin : g_led
            assign leds_ext[gi] = leds[gi];
        end else begin : g_noled
            assign leds_ext[gi] = 1'b0;
        end
        assign data_bytes[16*gi +: 8]     = digit_snap_reg[8*gi +: 8];
        assign data_bytes[16*gi + 8 +: 8] = {7'b0, led_snap_reg[gi]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_snap_reg  <= '0;
            led_snap_reg    <= '0;
            bright_snap_reg <= '0;
            on_snap_reg     <= 1'b0;
        end else if (snap) begin
            digit_snap_reg  <= digits_ext;
            led_snap_reg    <= leds_ext;
            bright_snap_reg <= brightness;
            on_snap_reg     <= display_on;
        end
    end

    always_comb begin
        case (txn_reg)
            2'd1:    last_byte = 5'd16;
            2'd3:    last_byte = 5'd4;
            default: last_byte = 5'd0;
        endcase
    end

    assign reading  = (txn_reg == 2'd3) && (byte_reg != 5'd0);
    assign key_byte = 2'(byte_reg - 5'd1);
    assign key_idx  = {key_byte, bit_reg};

    always_comb begin
        state_next      = state_reg;
        div_next        = div_reg + 1'b1;
        bit_next        = bit_reg;
        byte_next       = byte_reg;
        txn_next        = txn_reg;
        key_shift_next  = key_shift_reg;
        keys_next       = keys_reg;
        keys_valid_next = 1'b0;
        frame_done_next = 1'b0;
        snap            = 1'b0;
        case (state_reg)
            IDLE: begin
                div_next = '0;
                if (enable) begin
                    state_next = STB_SETUP;
                    txn_next   = 2'd0;
                    byte_next  = 5'd0;
                    snap       = 1'b1;
                end
            end
            STB_SETUP: begin
                if (div_reg == HALF_LAST) begin
                    state_next = BIT_LO;
                    div_next   = '0;
                    bit_next   = 3'd0;
                end
            end
            BIT_LO: begin
                if (div_reg == HALF_LAST) begin
                    state_next = BIT_HI;
                    div_next   = '0;
                end
            end
            BIT_HI: begin
                if (div_reg == HALF_LAST) begin
                    div_next = '0;
                    if (reading)
                        key_shift_next[key_idx] = bus.tm1638_dio_in;
                    if (bit_reg != 3'd7) begin
                        state_next = BIT_LO;
                        bit_next   = bit_reg + 3'd1;
                    end else if (byte_reg == last_byte) begin
                        state_next = STB_GAP;
                        // Publish the whole key word at once, including the bit sampled now.
                        if (txn_reg == 2'd3) begin
                            keys_next       = key_shift_next;
                            keys_valid_next = 1'b1;
                            frame_done_next = 1'b1;
                        end
                    end else if (txn_reg == 2'd3 && byte_reg == 5'd0) begin
                        state_next = TURN;
                        byte_next  = 5'd1;
                    end else begin
                        state_next = BIT_LO;
                        bit_next   = 3'd0;
                        byte_next  = byte_reg + 5'd1;
                    end
                end
            end
            TURN: begin
                if (div_reg == GAP_LAST) begin
                    state_next = BIT_LO;
                    div_next   = '0;
                    bit_next   = 3'd0;
                end
            end
            STB_GAP: begin
                if (div_reg == GAP_LAST) begin
                    div_next = '0;
                    if (txn_reg != 2'd3) begin
                        state_next = STB_SETUP;
                        txn_next   = txn_reg + 2'd1;
                        byte_next  = 5'd0;
                    end else if (enable) begin
                        state_next = STB_SETUP;
                        txn_next   = 2'd0;
                        byte_next  = 5'd0;
                        snap       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign data_idx = 4'(byte_next - 5'd1);

    always_comb begin
        tx_byte = 8'h00;
        case (txn_next)
            2'd0: tx_byte = 8'h40;
            2'd1: tx_byte = (byte_next == 5'd0) ? 8'hC0 : data_bytes[{data_idx, 3'b000} +: 8];
            2'd2: tx_byte = {4'b1000, on_snap_reg, bright_snap_reg};
            2'd3: tx_byte = (byte_next == 5'd0) ? 8'h42 : 8'h00;
            default: tx_byte = 8'h00;
        endcase
    end

    // Pad outputs are registered from next-state values so they never glitch.
    always_comb begin
        tclk_next    = (state_next != BIT_LO);
        stb_next     = (state_next == IDLE) || (state_next == STB_GAP);
        dio_en_next  = (state_next != IDLE) &&
                       !(txn_next == 2'd3 &&
                         (state_next == TURN || state_next == STB_GAP || byte_next != 5'd0));
        dio_out_next = (state_next == BIT_LO) ? tx_byte[bit_next] : dio_out_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            div_reg        <= '0;
            bit_reg        <= '0;
            byte_reg       <= '0;
            txn_reg        <= '0;
            key_shift_reg  <= '0;
            keys_reg       <= '0;
            keys_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            tclk_reg       <= 1'b1;
            stb_reg        <= 1'b1;
            dio_out_reg    <= 1'b0;
            dio_en_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            bit_reg        <= bit_next;
            byte_reg       <= byte_next;
            txn_reg        <= txn_next;
            key_shift_reg  <= key_shift_next;
            keys_reg       <= keys_next;
            keys_valid_reg <= keys_valid_next;
            frame_done_reg <= frame_done_next;
            tclk_reg       <= tclk_next;
            stb_reg        <= stb_next;
            dio_out_reg    <= dio_out_next;
            dio_en_reg     <= dio_en_next;
        end
    end

    assign keys                  = keys_reg;
    assign keys_valid            = keys_valid_reg;
    assign frame_done            = frame_done_reg;
    assign bus.tm1638_clk        = tclk_reg;
    assign bus.tm1638_stb        = stb_reg;
    assign bus.tm1638_dio_out    = dio_out_reg;
    assign bus.tm1638_dio_out_en = dio_en_reg;

endmodule

// File: tb/tb_tm1638_frame_driver.sv
// Bench for tm1638_frame_driver: a TM1638 bus model decodes written bytes and serves key bytes,
// checked against a scoreboard filled whenever new display inputs are driven.
module tb_tm1638_frame_driver;
    localparam int CLK_DIV   = 2;
    localparam int FRAME_CYC = 398 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] digits = '0;
    logic [7:0]  leds = '0;
    logic [2:0]  brightness = '0;
    logic        display_on = 1'b0;
    logic [31:0] keys;
    logic        keys_valid;
    logic        frame_done;
    logic        dio_in_drv = 1'b0;

    tm1638_frame_driver_if bus();
    assign bus.tm1638_dio_in = dio_in_drv;

    tm1638_frame_driver #(.CLK_DIV(CLK_DIV), .N_DIGITS(8), .N_LEDS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .digits     (digits),
        .leds       (leds),
        .brightness (brightness),
        .display_on (display_on),
        .keys       (keys),
        .keys_valid (keys_valid),
        .frame_done (frame_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [63:0] digits;
        logic [7:0]  leds;
        logic [2:0]  bright;
        logic        on;
        logic [31:0] key_seq;   // [31:24] is the first key byte on the wire
        logic [7:0]  exp_t3;
        logic [31:0] exp_keys;
    } vec_t;
    vec_t vecs[4];

    logic [7:0]  exp_wr_q[$];
    logic [31:0] exp_keys_q[$];
    logic [31:0] key_seq_cur = '0;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [63:0] d, input logic [7:0] l,
                              input logic [7:0] t3, input logic [31:0] ek);
        exp_wr_q.push_back(8'h40);
        exp_wr_q.push_back(8'hC0);
        for (int i = 0; i < 8; i++) begin
            exp_wr_q.push_back(d[8*i +: 8]);
            exp_wr_q.push_back({7'b0, l[i]});
        end
        exp_wr_q.push_back(t3);
        exp_wr_q.push_back(8'h42);
        exp_keys_q.push_back(ek);
    endtask

    task automatic drive_vec(input int v);
        digits      = vecs[v].digits;
        leds        = vecs[v].leds;
        brightness  = vecs[v].bright;
        display_on  = vecs[v].on;
        key_seq_cur = vecs[v].key_seq;
        push_frame(vecs[v].digits, vecs[v].leds, vecs[v].exp_t3, vecs[v].exp_keys);
    endtask

    int last_fd = 0;
    task automatic wait_fd(input string tag, output int ok);
        int n;
        tick();
        n = 1;
        while (frame_done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        ok = (frame_done === 1'b1) ? 1 : 0;
        if (ok == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no frame_done want pulse within 2000 cycles", tag);
        end
    endtask

    // TM1638 device model: decode bits on serial-clock rises, serve key bits on falls.
    logic prev_tclk = 1'b1, prev_stb = 1'b1, prev_kv = 1'b0, is_read = 1'b0;
    logic [7:0] sh = '0;
    int bits_done = 0, byte_idx = 0, kv_seen = 0, n_rd;
    always @(negedge clk) begin
        if (prev_stb === 1'b1 && bus.tm1638_stb === 1'b0) begin
            bits_done = 0;
            byte_idx  = 0;
            is_read   = 1'b0;
        end
        if (prev_stb === 1'b0 && bus.tm1638_stb === 1'b1)
            $display("txn end cyc=%0d bytes=%0d read=%0b", cyc, byte_idx, is_read);
        if (bus.tm1638_stb === 1'b0 && prev_tclk === 1'b0 && bus.tm1638_clk === 1'b1) begin
            if (is_read) begin
                chk("dio_en_read", 32'(bus.tm1638_dio_out_en), 32'd0);
            end else begin
                chk("dio_en_write", 32'(bus.tm1638_dio_out_en), 32'd1);
                sh[bits_done % 8] = bus.tm1638_dio_out;
            end
            bits_done++;
            if (bits_done % 8 == 0) begin
                if (!is_read) begin
                    if (exp_wr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL wr_byte: got %h want none", sh);
                    end else begin
                        chk("wr_byte", 32'(sh), 32'(exp_wr_q.pop_front()));
                    end
                    if (byte_idx == 0 && sh == 8'h42) is_read = 1'b1;
                end
                byte_idx++;
            end
        end
        if (bus.tm1638_stb === 1'b0 && prev_tclk === 1'b1 && bus.tm1638_clk === 1'b0) begin
            if (is_read && bits_done >= 8 && bits_done < 40) begin
                n_rd = bits_done - 8;
                dio_in_drv = key_seq_cur[24 - 8*(n_rd/8) + n_rd%8];
            end
        end
        if (keys_valid === 1'b1) begin
            kv_seen++;
            chk("kv_single", 32'(prev_kv), 32'd0);
            chk("fd_with_kv", 32'(frame_done), 32'd1);
            if (exp_keys_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL keys: got %h want none", keys);
            end else begin
                chk("keys", keys, exp_keys_q.pop_front());
            end
        end else if (frame_done === 1'b1) begin
            chk("kv_with_fd", 32'(keys_valid), 32'd1);
        end
        prev_kv   = keys_valid;
        prev_tclk = bus.tm1638_clk;
        prev_stb  = bus.tm1638_stb;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ok, kvb, busy;
        vecs[0] = '{64'h0, 8'h00, 3'd7, 1'b1, 32'h0000_0000, 8'h8F, 32'h0000_0000};
        vecs[1] = '{64'h0000_0000_0000_003F, 8'b0000_0001, 3'd5, 1'b1, 32'h0400_4001, 8'h8D, 32'h0140_0004};
        vecs[2] = '{64'h7F07_7D6D_664F_5B06, 8'hA5, 3'd0, 1'b0, 32'hFF80_015A, 8'h80, 32'h5A01_80FF};
        vecs[3] = '{64'h8001_4002_2004_1008, 8'h3C, 3'd3, 1'b1, 32'h1234_5678, 8'h8B, 32'h7856_3412};

        repeat (3) tick();
        chk("rst_tclk", 32'(bus.tm1638_clk), 32'd1);
        chk("rst_stb", 32'(bus.tm1638_stb), 32'd1);
        chk("rst_dio_out", 32'(bus.tm1638_dio_out), 32'd0);
        chk("rst_dio_en", 32'(bus.tm1638_dio_out_en), 32'd0);
        chk("rst_keys", keys, 32'd0);
        chk("rst_kv", 32'(keys_valid), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);

        drive_vec(0);
        enable = 1'b1;
        rst = 1'b0;
        n = 0;
        while (bus.tm1638_stb !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk("stb_fall_within2", 32'(bus.tm1638_stb === 1'b0 && n <= 2), 32'd1);

        // Table-driven frames, one vector per continuous frame.
        for (int v = 0; v < 4; v++) begin
            wait_fd($sformatf("frame%0d", v), ok);
            if (ok != 0 && v > 0) chk("frame_period", 32'(cyc - last_fd), 32'(FRAME_CYC));
            last_fd = cyc;
            if (v < 3) drive_vec(v + 1);
        end

        // Inputs changed mid-T2 must only show up in the following frame.
        drive_vec(1);
        repeat (100) tick();
        digits     = vecs[2].digits;
        leds       = vecs[2].leds;
        brightness = vecs[2].bright;
        display_on = vecs[2].on;
        push_frame(vecs[2].digits, vecs[2].leds, vecs[2].exp_t3, vecs[1].exp_keys);
        wait_fd("frame_old", ok);
        if (ok != 0) chk("frame_period", 32'(cyc - last_fd), 32'(FRAME_CYC));
        last_fd = cyc;
        push_frame(vecs[2].digits, vecs[2].leds, vecs[2].exp_t3, vecs[1].exp_keys);
        wait_fd("frame_new", ok);
        if (ok != 0) chk("frame_period", 32'(cyc - last_fd), 32'(FRAME_CYC));
        last_fd = cyc;

        // Dropping enable mid-frame lets the frame finish, then the bus idles.
        repeat (300) tick();
        enable = 1'b0;
        wait_fd("frame_last", ok);
        busy = 0;
        repeat (900) begin
            tick();
            if (bus.tm1638_stb !== 1'b1) busy++;
        end
        chk("stb_idle_after_disable", 32'(busy), 32'd0);
        chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        chk("keys_queue_drained", 32'(exp_keys_q.size()), 32'd0);

        // Reset in the middle of the T4 read phase.
        drive_vec(3);
        enable = 1'b1;
        n = 0;
        while (!(bus.tm1638_stb === 1'b0 && bus.tm1638_dio_out_en === 1'b0) && n < 2000) begin
            tick();
            n++;
        end
        chk("reached_read_phase", 32'(n < 2000), 32'd1);
        repeat (20) tick();
        kvb = kv_seen;
        rst = 1'b1;
        tick();
        chk("mid_rst_stb", 32'(bus.tm1638_stb), 32'd1);
        chk("mid_rst_tclk", 32'(bus.tm1638_clk), 32'd1);
        chk("mid_rst_dio_en", 32'(bus.tm1638_dio_out_en), 32'd0);
        chk("mid_rst_keys", keys, 32'd0);
        chk("mid_rst_kv", 32'(keys_valid), 32'd0);
        exp_keys_q.delete();
        rst = 1'b0;
        enable = 1'b0;
        repeat (900) tick();
        chk("no_kv_after_rst", 32'(kv_seen - kvb), 32'd0);
        chk("keys_after_rst", keys, 32'd0);
        chk("wr_queue_after_rst", 32'(exp_wr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
